// File: rtl/fp_adder_pkg.sv
// Shared constants and the normalized-significand record used by the FP adder stages.
package fp_adder_pkg;

    localparam int EXP_W   = 8;
    localparam int MANT_W  = 24;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam int E_W     = EXP_W + 2;
    localparam int NORM_W  = MANT_W + 3;
    localparam logic [4:0] LEAD_ZERO = 5'd0;

    // e is carried two bits wider than the biased exponent and read as signed.
    typedef struct packed {
        logic              sign;
        logic [E_W-1:0]    e;
        logic [MANT_W-1:0] m;
        logic              g;
        logic              r;
        logic              s;
        logic              zero;
    } norm_t;

endpackage

// File: rtl/fp_adder_normalize_round_shifter.sv
// Left barrel shifter over {significand, g, r, s} with the sticky bit folded back in.
module fp_norm_shifter
    import fp_adder_pkg::*;
(
    input  logic [NORM_W-1:0] data_i,
    input  logic [4:0]        amt_i,
    input  logic              sticky_i,
    output logic [NORM_W-2:0] mgr_o,
    output logic              sticky_o
);

    logic [NORM_W-1:0] v;

    always_comb begin
        v = data_i;
        if (amt_i[0]) v = v << 1;
        if (amt_i[1]) v = v << 2;
        if (amt_i[2]) v = v << 4;
        if (amt_i[3]) v = v << 8;
        if (amt_i[4]) v = v << 16;
    end

    assign mgr_o    = v[NORM_W-1:1];
    assign sticky_o = v[0] | sticky_i;

endmodule

// File: rtl/fp_adder_normalize_round.sv
// Post-add normalize and round-to-nearest-even stage; packs an IEEE-754 binary32 result.
module fp_adder_normalize_round
    import fp_adder_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 24
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [MANT_W:0]         in_mant,
    input  logic [2:0]              in_grs,
    input  logic [4:0]              lead_pos,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MANT_W-1:0] out_data,
    output logic                    out_ovf,
    output logic                    out_unf
);

    logic        vld_p1_q;
    logic        vld_p2_q;
    logic        adv2;
    norm_t       norm_d;
    norm_t       pay_p1_q;
    logic [4:0]  sh;
    logic [25:0] sh_mgr;
    logic        sh_sticky;
    logic        up;
    logic        carry;
    logic [22:0] frac_r;
    logic signed [9:0] e_r;
    logic [31:0] data_d;
    logic        ovf_d;
    logic        unf_d;
    logic [31:0] out_data_q;
    logic        out_ovf_q;
    logic        out_unf_q;

    assign adv2     = !vld_p2_q || out_ready;
    assign in_ready = !vld_p1_q || adv2;
    assign sh       = 5'd24 - lead_pos;

    fp_norm_shifter u_shift (
        .data_i   ({in_mant[MANT_W-1:0], in_grs}),
        .amt_i    (sh),
        .sticky_i (in_grs[0]),
        .mgr_o    (sh_mgr),
        .sticky_o (sh_sticky)
    );

    // Stage 1: normalize
    always_comb begin
        norm_d      = '0;
        norm_d.sign = in_sign;
        if (in_mant[MANT_W]) begin
            norm_d.m = in_mant[MANT_W:1];
            norm_d.g = in_mant[0];
            norm_d.r = in_grs[2];
            norm_d.s = |in_grs[1:0];
            norm_d.e = {2'b00, in_exp} + 10'd1;
        end else if (lead_pos == LEAD_ZERO) begin
            // All-zero sum is an exact +0; bits only below the significand can't be represented.
            if (in_grs == 3'b000) begin
                norm_d.zero = 1'b1;
                norm_d.sign = 1'b0;
            end else begin
                norm_d.e = '0;
            end
        end else begin
            {norm_d.m, norm_d.g, norm_d.r} = sh_mgr;
            norm_d.s = sh_sticky;
            norm_d.e = {2'b00, in_exp} - {5'd0, sh};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1_q <= 1'b0;
        end else if (in_ready) begin
            vld_p1_q <= in_valid;
        end
        if (in_ready && in_valid) begin
            pay_p1_q <= norm_d;
        end
    end

    // Stage 2: round and pack
    always_comb begin
        up     = pay_p1_q.g & (pay_p1_q.r | pay_p1_q.s | pay_p1_q.m[0]);
        carry  = up & (&pay_p1_q.m);
        frac_r = pay_p1_q.m[22:0] + {22'd0, up};
        e_r    = $signed(pay_p1_q.e) + $signed({9'd0, carry});
        data_d = '0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        if (!pay_p1_q.zero) begin
            if (e_r >= 10'sd255) begin
                data_d = {pay_p1_q.sign, 8'hFF, 23'd0};
                ovf_d  = 1'b1;
            end else if (e_r <= 10'sd0) begin
                data_d = {pay_p1_q.sign, 31'd0};
                unf_d  = 1'b1;
            end else begin
                data_d = {pay_p1_q.sign, e_r[7:0], frac_r};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2_q   <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
            out_unf_q  <= 1'b0;
        end else if (adv2) begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                out_data_q <= data_d;
                out_ovf_q  <= ovf_d;
                out_unf_q  <= unf_d;
            end
        end
    end

    assign out_valid = vld_p2_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_unf   = out_unf_q;

endmodule

// File: tb/tb_fp_adder_normalize_round.sv
// Directed-vector bench for the FP adder normalize/round stage with an in-order result scoreboard.
module tb_fp_adder_normalize_round;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic [2:0]  in_grs;
    logic [4:0]  lead_pos;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_unf;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] d;
        logic        o;
        logic        u;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    fp_adder_normalize_round dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .in_grs    (in_grs),
        .lead_pos  (lead_pos),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                mon_e = q.pop_front();
                check({mon_e.tag, "_data"}, out_data, mon_e.d);
                check({mon_e.tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, mon_e.o});
                check({mon_e.tag, "_unf"}, {31'd0, out_unf}, {31'd0, mon_e.u});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input string tag, input logic sgn, input logic [7:0] ex,
                        input logic [24:0] mt, input logic [2:0] grs, input logic [4:0] lp,
                        input logic [31:0] d, input logic o, input logic u);
        logic rdy;
        logic acc;
        acc      = 1'b0;
        in_sign  = sgn;
        in_exp   = ex;
        in_mant  = mt;
        in_grs   = grs;
        lead_pos = lp;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                q.push_back('{tag, d, o, u});
                acc = 1'b1;
                break;
            end
        end
        #1;
        if (!acc) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (q.size() == 0) break;
        end
        #1;
        check({tag, "_drained"}, q.size(), 32'd0);
    endtask

    function automatic logic [31:0] beat_exp(input int k);
        logic [7:0] e8;
        e8 = 8'(101 + k);
        return {1'b0, e8, 23'd0};
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int   acc;
        logic rdy;
        reset = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0;
        in_mant = '0; in_grs = '0; lead_pos = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        check("rst_out_unf", {31'd0, out_unf}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        send("t1", 1'b0, 8'd127, 25'h1000000, 3'b000, 5'd0, 32'h40000000, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_lat_1cyc", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("t1_lat_2cyc", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        drain("t1");

        send("t2_shift23", 1'b0, 8'd127, 25'h0000001, 3'b000, 5'd1,  32'h34000000, 1'b0, 1'b0);
        send("t3_rnd_carry", 1'b0, 8'd127, 25'h0FFFFFF, 3'b100, 5'd24, 32'h40000000, 1'b0, 1'b0);
        send("t4_ovf",     1'b0, 8'd254, 25'h1000000, 3'b000, 5'd0,  32'h7F800000, 1'b1, 1'b0);
        send("t4_unf",     1'b0, 8'd10,  25'h0000001, 3'b000, 5'd1,  32'h00000000, 1'b0, 1'b1);
        send("t5_zero",    1'b1, 8'd127, 25'h0000000, 3'b000, 5'd0,  32'h00000000, 1'b0, 1'b0);
        send("neg",        1'b1, 8'd127, 25'h1000000, 3'b000, 5'd0,  32'hC0000000, 1'b0, 1'b0);
        send("no_round",   1'b0, 8'd127, 25'h0C00000, 3'b011, 5'd24, 32'h3FC00000, 1'b0, 1'b0);
        send("tie_even",   1'b0, 8'd127, 25'h0800000, 3'b100, 5'd24, 32'h3F800000, 1'b0, 1'b0);
        send("tie_odd",    1'b0, 8'd127, 25'h0800001, 3'b100, 5'd24, 32'h3F800002, 1'b0, 1'b0);
        send("carry_rnd",  1'b0, 8'd127, 25'h1000001, 3'b100, 5'd0,  32'h40000001, 1'b0, 1'b0);
        send("shift1_rnd", 1'b0, 8'd127, 25'h0400000, 3'b110, 5'd23, 32'h3F000002, 1'b0, 1'b0);
        send("shift1_stk", 1'b0, 8'd127, 25'h0400000, 3'b001, 5'd23, 32'h3F000000, 1'b0, 1'b0);
        send("grs_only",   1'b1, 8'd127, 25'h0000000, 3'b010, 5'd0,  32'h80000000, 1'b0, 1'b1);
        send("min_norm",   1'b0, 8'd1,   25'h0800000, 3'b000, 5'd24, 32'h00800000, 1'b0, 1'b0);
        send("max_norm",   1'b0, 8'd254, 25'h0FFFFFF, 3'b000, 5'd24, 32'h7F7FFFFF, 1'b0, 1'b0);
        send("ovf_by_rnd", 1'b0, 8'd254, 25'h0FFFFFF, 3'b100, 5'd24, 32'h7F800000, 1'b1, 1'b0);
        send("e_zero",     1'b0, 8'd23,  25'h0000001, 3'b000, 5'd1,  32'h00000000, 1'b0, 1'b1);
        send("e_one",      1'b0, 8'd24,  25'h0000001, 3'b000, 5'd1,  32'h00800000, 1'b0, 1'b0);
        in_valid = 1'b0;
        drain("vectors");

        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            in_sign = 1'b0; in_exp = 8'(100 + acc); in_mant = 25'h1000000;
            in_grs = 3'b000; lead_pos = 5'd0; in_valid = 1'b1;
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                q.push_back('{$sformatf("stall_b%0d", acc), beat_exp(acc), 1'b0, 1'b0});
                acc++;
            end
            #1;
        end
        check("stall_accepted", acc, 32'd2);
        @(negedge clk);
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        check("stall_hold", out_data, beat_exp(0));
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = acc; k < 4; k++) begin
            send($sformatf("stall_b%0d", k), 1'b0, 8'(100 + k), 25'h1000000, 3'b000, 5'd0,
                 beat_exp(k), 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        drain("stall");

        out_ready = 1'b0;
        send("rst_a", 1'b0, 8'd127, 25'h1000000, 3'b000, 5'd0, 32'h40000000, 1'b0, 1'b0);
        send("rst_b", 1'b0, 8'd128, 25'h1000000, 3'b000, 5'd0, 32'h40800000, 1'b0, 1'b0);
        in_valid = 1'b0;
        check("rst_inflight_q", q.size(), 32'd2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        q.delete();
        @(negedge clk);
        check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("rst_no_stale", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;

        send("post_rst", 1'b0, 8'd127, 25'h0000001, 3'b000, 5'd1, 32'h34000000, 1'b0, 1'b0);
        in_valid = 1'b0;
        drain("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
